// File: rtl/seq_ctrl_unit.sv
// Special-register and sequencing unit: PC, bit masks, hardware loop registers with a
// nested-loop stack, and the external pin port. Exports the one-shot register-file write mask.
module seq_ctrl_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LOOP_DEPTH = 4,
  localparam int unsigned BS_W      = $clog2(WIDTH) + 2,
  localparam int unsigned DW        = $clog2(LOOP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             sp_we,
  input  logic [2:0]       sp_waddr,
  input  logic [WIDTH-1:0] sp_wdata,
  input  logic             sp_zero,
  input  logic             sp_imm,
  input  logic             sp_accum,
  input  logic [BS_W-1:0]  sp_bitsel,
  input  logic [2:0]       sp_raddr,
  output logic [WIDTH-1:0] sp_rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] bms_out,
  output logic [DW-1:0]    loop_depth,
  output logic             loop_ovf
);

  typedef enum logic [2:0] {
    AddrPc    = 3'd0,
    AddrBm    = 3'd1,
    AddrBms   = 3'd2,
    AddrLp    = 3'd3,
    AddrLc    = 3'd4,
    AddrEp    = 3'd5,
    AddrDepth = 3'd6,
    AddrZero  = 3'd7
  } sp_addr_e;

  logic [WIDTH-1:0] pc_q, pc_d, bm_q, bm_d, bms_q, bms_d;
  logic [WIDTH-1:0] lp_q, lp_d, lc_q, lc_d, pin_q, pin_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] stk_lp_q [LOOP_DEPTH];
  logic [WIDTH-1:0] stk_lc_q [LOOP_DEPTH];

  logic [WIDTH-1:0] d_eff, m_eff, cmask, bm_new, lc_src, lc_new, top_lp, top_lc;
  logic [BS_W-2:0]  n_raw;
  logic             push, stk_full;

  assign n_raw    = sp_bitsel[BS_W-2:0];
  assign stk_full = (depth_q == DW'(LOOP_DEPTH));

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Effective data/mask, computed bit mask and the candidate new loop count.
  always_comb begin
    d_eff = sp_zero ? '0 : sp_wdata;
    m_eff = (sp_zero || sp_waddr == AddrBm || sp_waddr == AddrBms) ? '1 : bms_q;
    // Bits below n are set; n beyond WIDTH saturates naturally since i never reaches it.
    cmask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cmask[i] = (i < int'(n_raw));
    end
    if (sp_bitsel[BS_W-1]) cmask = ~cmask;
    bm_new = sp_imm ? cmask : d_eff;
    lc_src = sp_accum ? (lc_q + d_eff) : d_eff;
    lc_new = merge(lc_q, lc_src, m_eff);
  end

  // Top-of-stack pair, valid only when the stack is non-empty.
  always_comb begin
    top_lp = '0;
    top_lc = '0;
    for (int i = 0; i < int'(LOOP_DEPTH); i++) begin
      if (DW'(i + 1) == depth_q) begin
        top_lp = stk_lp_q[i];
        top_lc = stk_lc_q[i];
      end
    end
  end

  // Next-state decode for an accepted instruction.
  always_comb begin
    pc_d    = pc_q + WIDTH'(2);
    bm_d    = bm_q;
    bms_d   = bm_q;
    lp_d    = lp_q;
    lc_d    = lc_q;
    pin_d   = pin_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (sp_we) begin
      case (sp_waddr)
        AddrPc: pc_d = merge(pc_q, d_eff, m_eff);
        AddrBm: begin
          bm_d  = bm_new;
          bms_d = bm_new;
        end
        AddrBms: bms_d = bm_new;
        AddrLp: begin
          lp_d = merge(lp_q, d_eff, m_eff);
          if (sp_accum) begin
            if (stk_full) begin
              ovf_d = 1'b1;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end
        end
        AddrLc: begin
          lc_d = lc_new;
          if (lc_new != '0) begin
            pc_d = lp_q;
          end else if (depth_q != '0) begin
            // Inner loop finished: restore the enclosing loop and fall through.
            lp_d    = top_lp;
            lc_d    = top_lc;
            depth_d = depth_q - DW'(1);
          end
        end
        AddrEp: pin_d = merge(pin_q, d_eff, m_eff);
        default: ;
      endcase
    end
  end

  // State registers; a stalled cycle holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      bm_q    <= '0;
      bms_q   <= '0;
      lp_q    <= '0;
      lc_q    <= '0;
      pin_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(LOOP_DEPTH); i++) begin
        stk_lp_q[i] <= '0;
        stk_lc_q[i] <= '0;
      end
    end else if (instr_valid) begin
      pc_q    <= pc_d;
      bm_q    <= bm_d;
      bms_q   <= bms_d;
      lp_q    <= lp_d;
      lc_q    <= lc_d;
      pin_q   <= pin_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < int'(LOOP_DEPTH); i++) begin
        if (push && DW'(i) == depth_q) begin
          stk_lp_q[i] <= lp_q;
          stk_lc_q[i] <= lc_q;
        end
      end
    end
  end

  // Combinational read network.
  always_comb begin
    sp_rdata = '0;
    case (sp_raddr)
      AddrPc:    sp_rdata = pc_q + WIDTH'(2);
      AddrBm:    sp_rdata = bm_q;
      AddrBms:   sp_rdata = bms_q;
      AddrLp:    sp_rdata = lp_q;
      AddrLc:    sp_rdata = lc_q;
      AddrEp:    sp_rdata = pin_in;
      AddrDepth: sp_rdata = WIDTH'(depth_q);
      AddrZero:  sp_rdata = '0;
      default:   sp_rdata = '0;
    endcase
  end

  assign pc         = pc_q;
  assign pin_out    = pin_q;
  assign bms_out    = bms_q;
  assign loop_depth = depth_q;
  assign loop_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit (WIDTH=16, LOOP_DEPTH=2).
module tb_seq_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        sp_we = 1'b0;
  logic [2:0]  sp_waddr = '0;
  logic [15:0] sp_wdata = '0;
  logic        sp_zero = 1'b0;
  logic        sp_imm = 1'b0;
  logic        sp_accum = 1'b0;
  logic [5:0]  sp_bitsel = '0;
  logic [2:0]  sp_raddr = '0;
  logic [15:0] sp_rdata;
  logic [15:0] pin_in = '0;
  logic [15:0] pc;
  logic [15:0] pin_out;
  logic [15:0] bms_out;
  logic [1:0]  loop_depth;
  logic        loop_ovf;

  int n_pass  = 0;
  int n_total = 0;

  seq_ctrl_unit #(.WIDTH(16), .LOOP_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .sp_we       (sp_we),
    .sp_waddr    (sp_waddr),
    .sp_wdata    (sp_wdata),
    .sp_zero     (sp_zero),
    .sp_imm      (sp_imm),
    .sp_accum    (sp_accum),
    .sp_bitsel   (sp_bitsel),
    .sp_raddr    (sp_raddr),
    .sp_rdata    (sp_rdata),
    .pin_in      (pin_in),
    .pc          (pc),
    .pin_out     (pin_out),
    .bms_out     (bms_out),
    .loop_depth  (loop_depth),
    .loop_ovf    (loop_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] dat, input logic imm,
                    input logic acc, input logic zero, input logic [5:0] bs);
    instr_valid = 1'b1;
    sp_we       = 1'b1;
    sp_waddr    = a;
    sp_wdata    = dat;
    sp_imm      = imm;
    sp_accum    = acc;
    sp_zero     = zero;
    sp_bitsel   = bs;
    tick();
    sp_we    = 1'b0;
    sp_imm   = 1'b0;
    sp_accum = 1'b0;
    sp_zero  = 1'b0;
  endtask

  task automatic nop();
    instr_valid = 1'b1;
    sp_we       = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] a);
    sp_raddr = a;
    #1;
  endtask

  // Reset, then BM/BMS all-ones so masked writes pass full words; leaves pc = 2.
  task automatic init();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(3'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b010000);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_total++; if (pc !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (pin_out !== 16'h0000) $display("FAIL rst_pin: got %h want 0000", pin_out); else n_pass++;
    n_total++; if (bms_out !== 16'h0000) $display("FAIL rst_bms: got %h want 0000", bms_out); else n_pass++;
    n_total++; if (loop_depth !== 2'd0) $display("FAIL rst_depth: got %0d want 0", loop_depth); else n_pass++;
    n_total++; if (loop_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", loop_ovf); else n_pass++;
    rd(3'd0);
    n_total++; if (sp_rdata !== 16'h0002) $display("FAIL rst_rd_pc: got %h want 0002", sp_rdata); else n_pass++;
    tick();
    rst = 1'b0;
    nop();
    n_total++; if (pc !== 16'h0002) $display("FAIL nop_pc1: got %h want 0002", pc); else n_pass++;
    nop();
    n_total++; if (pc !== 16'h0004) $display("FAIL nop_pc2: got %h want 0004", pc); else n_pass++;
    nop();
    n_total++; if (pc !== 16'h0006) $display("FAIL nop_pc3: got %h want 0006", pc); else n_pass++;
    rd(3'd0);
    n_total++; if (sp_rdata !== 16'h0008) $display("FAIL nop_rd_pc: got %h want 0008", sp_rdata); else n_pass++;
    rd(3'd3);
    n_total++; if (sp_rdata !== 16'h0000) $display("FAIL nop_rd_lp: got %h want 0000", sp_rdata); else n_pass++;
  endtask

  task automatic test_mask();
    wr(3'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b000100);
    n_total++; if (bms_out !== 16'h000F) $display("FAIL bm_imm_bms: got %h want 000f", bms_out); else n_pass++;
    rd(3'd1);
    n_total++; if (sp_rdata !== 16'h000F) $display("FAIL bm_imm_bm: got %h want 000f", sp_rdata); else n_pass++;
    wr(3'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pin_out !== 16'h000F) $display("FAIL ep_masked: got %h want 000f", pin_out); else n_pass++;
    wr(3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b100100);
    n_total++; if (bms_out !== 16'hFFF0) $display("FAIL bms_inv: got %h want fff0", bms_out); else n_pass++;
    rd(3'd1);
    n_total++; if (sp_rdata !== 16'h000F) $display("FAIL bms_keeps_bm: got %h want 000f", sp_rdata); else n_pass++;
    wr(3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pin_out !== 16'h000F) $display("FAIL ep_upper_clr: got %h want 000f", pin_out); else n_pass++;
    n_total++; if (bms_out !== 16'h000F) $display("FAIL bms_restore: got %h want 000f", bms_out); else n_pass++;
    wr(3'd5, 16'hFFFF, 1'b0, 1'b0, 1'b1, 6'b0);
    n_total++; if (pin_out !== 16'h0000) $display("FAIL ep_zero: got %h want 0000", pin_out); else n_pass++;
    pin_in = 16'hA5A5;
    rd(3'd5);
    n_total++; if (sp_rdata !== 16'hA5A5) $display("FAIL rd_ep: got %h want a5a5", sp_rdata); else n_pass++;
    rd(3'd7);
    n_total++; if (sp_rdata !== 16'h0000) $display("FAIL rd_zero: got %h want 0000", sp_rdata); else n_pass++;
    wr(3'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b011111);
    rd(3'd1);
    n_total++; if (sp_rdata !== 16'hFFFF) $display("FAIL bm_sat: got %h want ffff", sp_rdata); else n_pass++;
  endtask

  task automatic test_pc();
    init();
    wr(3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h1234) $display("FAIL pc_write: got %h want 1234", pc); else n_pass++;
    rd(3'd0);
    n_total++; if (sp_rdata !== 16'h1236) $display("FAIL pc_rd: got %h want 1236", sp_rdata); else n_pass++;
    wr(3'd0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 6'b0);
    rd(3'd0);
    n_total++; if (sp_rdata !== 16'h0000) $display("FAIL pc_rd_wrap: got %h want 0000", sp_rdata); else n_pass++;
    nop();
    n_total++; if (pc !== 16'h0000) $display("FAIL pc_wrap: got %h want 0000", pc); else n_pass++;
    wr(3'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 6'b000001);
    wr(3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0003) $display("FAIL pc_masked: got %h want 0003", pc); else n_pass++;
    wr(3'd7, 16'h5555, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0005) $display("FAIL addr7_pc: got %h want 0005", pc); else n_pass++;
    n_total++; if (bms_out !== 16'hFFFF) $display("FAIL addr7_bms: got %h want ffff", bms_out); else n_pass++;
  endtask

  task automatic test_loop();
    init();
    wr(3'd3, 16'h0010, 1'b0, 1'b0, 1'b0, 6'b0);
    wr(3'd4, 16'h0003, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0010) $display("FAIL loop_load_pc: got %h want 0010", pc); else n_pass++;
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0010) $display("FAIL loop_pc1: got %h want 0010", pc); else n_pass++;
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0010) $display("FAIL loop_pc2: got %h want 0010", pc); else n_pass++;
    rd(3'd4);
    n_total++; if (sp_rdata !== 16'h0001) $display("FAIL loop_lc1: got %h want 0001", sp_rdata); else n_pass++;
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0012) $display("FAIL loop_exit_pc: got %h want 0012", pc); else n_pass++;
    rd(3'd4);
    n_total++; if (sp_rdata !== 16'h0000) $display("FAIL loop_exit_lc: got %h want 0000", sp_rdata); else n_pass++;
  endtask

  task automatic test_nested();
    init();
    wr(3'd3, 16'h0020, 1'b0, 1'b0, 1'b0, 6'b0);
    wr(3'd4, 16'h0002, 1'b0, 1'b0, 1'b0, 6'b0);
    wr(3'd3, 16'h0040, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (loop_depth !== 2'd1) $display("FAIL nest_push_depth: got %0d want 1", loop_depth); else n_pass++;
    rd(3'd6);
    n_total++; if (sp_rdata !== 16'h0001) $display("FAIL nest_rd_depth: got %h want 0001", sp_rdata); else n_pass++;
    wr(3'd4, 16'h0002, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0040) $display("FAIL nest_inner_pc: got %h want 0040", pc); else n_pass++;
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'b0);
    wr(3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (pc !== 16'h0042) $display("FAIL nest_exit_pc: got %h want 0042", pc); else n_pass++;
    n_total++; if (loop_depth !== 2'd0) $display("FAIL nest_pop_depth: got %0d want 0", loop_depth); else n_pass++;
    rd(3'd3);
    n_total++; if (sp_rdata !== 16'h0020) $display("FAIL nest_pop_lp: got %h want 0020", sp_rdata); else n_pass++;
    rd(3'd4);
    n_total++; if (sp_rdata !== 16'h0002) $display("FAIL nest_pop_lc: got %h want 0002", sp_rdata); else n_pass++;
  endtask

  task automatic test_overflow();
    init();
    wr(3'd3, 16'h0100, 1'b0, 1'b1, 1'b0, 6'b0);
    wr(3'd3, 16'h0200, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (loop_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", loop_ovf); else n_pass++;
    wr(3'd3, 16'h0300, 1'b0, 1'b1, 1'b0, 6'b0);
    n_total++; if (loop_depth !== 2'd2) $display("FAIL ovf_depth: got %0d want 2", loop_depth); else n_pass++;
    n_total++; if (loop_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", loop_ovf); else n_pass++;
    rd(3'd3);
    n_total++; if (sp_rdata !== 16'h0300) $display("FAIL ovf_lp: got %h want 0300", sp_rdata); else n_pass++;
    nop();
    wr(3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (loop_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", loop_ovf); else n_pass++;
    n_total++; if (loop_depth !== 2'd1) $display("FAIL ovf_pop_depth: got %0d want 1", loop_depth); else n_pass++;
    n_total++; if (pc !== 16'h000C) $display("FAIL ovf_pc: got %h want 000c", pc); else n_pass++;
    rd(3'd3);
    n_total++; if (sp_rdata !== 16'h0100) $display("FAIL ovf_pop_lp: got %h want 0100", sp_rdata); else n_pass++;
  endtask

  task automatic test_stall_reset();
    init();
    n_total++; if (loop_ovf !== 1'b0) $display("FAIL ovf_rst_clr: got %b want 0", loop_ovf); else n_pass++;
    wr(3'd3, 16'h0050, 1'b0, 1'b0, 1'b0, 6'b0);
    wr(3'd4, 16'h0003, 1'b0, 1'b0, 1'b0, 6'b0);
    instr_valid = 1'b0;
    sp_we       = 1'b1;
    sp_waddr    = 3'd4;
    sp_wdata    = 16'hFFFF;
    sp_accum    = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++; if (pc !== 16'h0050) $display("FAIL stall_pc: got %h want 0050", pc); else n_pass++;
    rd(3'd4);
    n_total++; if (sp_rdata !== 16'h0003) $display("FAIL stall_lc: got %h want 0003", sp_rdata); else n_pass++;
    instr_valid = 1'b1;
    tick();
    sp_we    = 1'b0;
    sp_accum = 1'b0;
    n_total++; if (sp_rdata !== 16'h0002) $display("FAIL unstall_lc: got %h want 0002", sp_rdata); else n_pass++;
    wr(3'd3, 16'h0060, 1'b0, 1'b1, 1'b0, 6'b0);
    wr(3'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 6'b0);
    n_total++; if (loop_depth !== 2'd1) $display("FAIL pre_rst_depth: got %0d want 1", loop_depth); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (pc !== 16'h0000) $display("FAIL arst_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (loop_depth !== 2'd0) $display("FAIL arst_depth: got %0d want 0", loop_depth); else n_pass++;
    n_total++; if (pin_out !== 16'h0000) $display("FAIL arst_pin: got %h want 0000", pin_out); else n_pass++;
    n_total++; if (bms_out !== 16'h0000) $display("FAIL arst_bms: got %h want 0000", bms_out); else n_pass++;
    n_total++; if (sp_rdata !== 16'h0000) $display("FAIL arst_lc: got %h want 0000", sp_rdata); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mask();
    test_pc();
    test_loop();
    test_nested();
    test_overflow();
    test_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
